dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Sequences and shares the single-port data-memory BRAM (synchronous read, 1-bit write enable)
//   between two requesters: port 0 = CPU load/store unit, port 1 = debug/loader port.
//   Round-robin arbitration, one access in flight, drives the BRAM ena/wea/addra/dina pins
//   and waits out the BRAM read latency before returning read data to the winning requester.
// PARAMETERS
//   ADDR_W      4   word-address width of the data memory
//   DATA_W      32  data width
//   RD_LATENCY  1   BRAM clock-to-douta latency in cycles (legal: 1..3)
// PORTS
//   clk         in   1       single clock, all logic on rising edge
//   rst         in   1       synchronous, active-high reset
//   m0_req      in   1       port 0 request; hold with fields stable until m0_gnt
//   m0_we       in   1       port 0: 1 = write, 0 = read
//   m0_addr     in   ADDR_W  port 0 word address
//   m0_wdata    in   DATA_W  port 0 write data
//   m0_gnt      out  1       1-cycle pulse: port 0 access issued to memory
//   m0_rvalid   out  1       1-cycle pulse: rdata holds port 0 read result
//   m1_req/m1_we/m1_addr/m1_wdata, m1_gnt/m1_rvalid: identical, port 1
//   rdata       out  DATA_W  registered read data, shared by both ports
//   busy        out  1       1 when state != IDLE
//   mem_en      out  1       to BRAM ena
//   mem_we      out  1       to BRAM wea[0]
//   mem_addr    out  ADDR_W  to BRAM addra
//   mem_wdata   out  DATA_W  to BRAM dina
//   mem_rdata   in   DATA_W  from BRAM douta
// BEHAVIOUR
//   FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE: if any req, pick winner, latch its we/addr/wdata + owner id -> ISSUE; else stay.
//   Arbitration: only one req -> it wins; both -> port NOT granted last wins (round-robin).
//     last_gnt pointer updated when entering ISSUE. After reset last_gnt=1 (port 0 wins first tie).
//   ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values;
//     owner's gnt=1. Write -> IDLE. Read -> WAIT with cnt=0.
//   WAIT: RD_LATENCY cycles, mem_en=0. On last WAIT cycle (cnt==RD_LATENCY-1) sample
//     mem_rdata into rdata -> RESP.
//   RESP (1 cycle): owner's rvalid=1, rdata valid -> IDLE.
//   Outside ISSUE: mem_en=0, mem_we=0; mem_addr/mem_wdata hold latched values (don't-care).
//   Timing (req first seen in IDLE at cycle T): write gnt+mem write at T+1, IDLE at T+2;
//     read gnt at T+1, rvalid at T+2+RD_LATENCY, IDLE at T+3+RD_LATENCY.
//   Requests are sampled in IDLE only; req raised during ISSUE/WAIT/RESP waits (no loss, no
//     grant). req dropped before gnt while not yet latched: no access. After latching,
//     access completes even if req drops.
//   rdata holds last read value until next read completes; never changes on writes.
//   gnt and rvalid never asserted on both ports in the same cycle; never on a non-owner.
//   Reset (any state, incl. mid-WAIT): state=IDLE, cnt=0, last_gnt=1, rdata=0, all gnt/rvalid=0,
//     mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0. In-flight read is dropped, no rvalid.
//   Address wrap: none; ADDR_W bits passed unchanged, every address legal.
// TESTING
//   1 Reset: rst high 2 cycles -> all outputs 0, busy=0; release with no req -> mem_en stays 0.
//   2 m0 write addr 3 data 0xDEADBEEF then m0 read addr 3 -> write gnt at T+1 with mem_en=1,
//     mem_we=1; read m0_rvalid at T+3 (RD_LATENCY=1), rdata=0xDEADBEEF, m1_rvalid=0.
//   3 m0 and m1 both reading continuously from reset -> grants alternate m0,m1,m0,m1;
//     each port's rvalid matches its own address's stored data.
//   4 m1 holds req continuously, m0 idle -> m1 granted back-to-back every 4 cycles (reads)
//     or 2 cycles (writes); m0 req then raised -> m0 wins next arbitration.
//   5 rst asserted in WAIT of m1 read -> next cycle IDLE, no m1_rvalid ever, rdata=0;
//     subsequent m0 read returns correct data.
//   6 RD_LATENCY=2 build: read at T -> m0_rvalid exactly at T+4, rdata equals BRAM
//     content; writes still complete at T+1.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin sharing of one single-port data BRAM between two
//            requesters, one access in flight, read latency waited out.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_cnt_last = 2'(RD_LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;
    logic              r_last_gnt;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_pick;
    logic              w_latch;
    logic              w_sample;

    // A lone requester always wins; on a tie the port not served last wins.
    assign w_pick = (m0_req & m1_req) ? ~r_last_gnt : m1_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_sample    = 1'b0;
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_req | m1_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en = 1'b1;
                mem_we = r_we;
                m0_gnt = ~r_owner;
                m1_gnt = r_owner;
                if (r_we) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = 2'd0;
                end
            end
            WAIT: begin
                if (r_cnt == c_cnt_last) begin
                    w_sample    = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            RESP: begin
                m0_rvalid   = ~r_owner;
                m1_rvalid   = r_owner;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_latch) begin
                r_owner    <= w_pick;
                r_last_gnt <= w_pick;
                r_we       <= w_pick ? m1_we    : m0_we;
                r_addr     <= w_pick ? m1_addr  : m0_addr;
                r_wdata    <= w_pick ? m1_wdata : m0_wdata;
            end
            if (w_sample) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter (RD_LATENCY 1 and 2 builds)
//            with behavioural BRAM models.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, busy, mem_en, mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, rdata;

    logic        b_req, b_we;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt, b_rvalid, b_m1_gnt, b_m1_rvalid, b_busy, b_mem_en, b_mem_we;
    logic [3:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata, b_rdata;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .RD_LATENCY(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(b_req), .m0_we(b_we), .m0_addr(b_addr), .m0_wdata(b_wdata),
        .m0_gnt(b_gnt), .m0_rvalid(b_rvalid),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(4'd0), .m1_wdata(32'd0),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid),
        .rdata(b_rdata), .busy(b_busy),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    // BRAM models: A has douta latency 1, B adds an output register (latency 2).
    logic [31:0] bram_a [16];
    logic [31:0] bram_b [16];
    logic [31:0] q_a, q_b1, q_b2;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                bram_a[i] <= pat(i);
                bram_b[i] <= pat(i);
            end
        end else begin
            if (mem_en) begin
                if (mem_we) bram_a[mem_addr] <= mem_wdata;
                else        q_a <= bram_a[mem_addr];
            end
            if (b_mem_en) begin
                if (b_mem_we) bram_b[b_mem_addr] <= b_mem_wdata;
                else          q_b1 <= bram_b[b_mem_addr];
            end
        end
        q_b2 <= q_b1;
    end
    assign mem_rdata   = q_a;
    assign b_mem_rdata = q_b2;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    exp_t        ea, eb;
    logic [31:0] ref_a [16];
    logic [31:0] ref_b [16];
    int          gport[$];
    int          gcyc[$];
    int          n_run = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m0_gnt || m1_gnt) check("a_gnt_excl", m0_gnt & m1_gnt, 0);
        if (m0_rvalid || m1_rvalid) begin
            check("a_rv_excl", m0_rvalid & m1_rvalid, 0);
            if (sb_a.size() == 0) begin
                check("a_rv_unexpected", {m0_rvalid, m1_rvalid}, 0);
            end else begin
                ea = sb_a.pop_front();
                check("a_rv_port", m1_rvalid, ea.port);
                check("a_rv_data", rdata, ea.data);
            end
        end
        if (b_rvalid || b_m1_rvalid) begin
            if (sb_b.size() == 0) begin
                check("b_rv_unexpected", {b_rvalid, b_m1_rvalid}, 0);
            end else begin
                eb = sb_b.pop_front();
                check("b_rv_port", b_m1_rvalid, eb.port);
                check("b_rv_data", b_rdata, eb.data);
            end
        end
    end

    function automatic logic gnt_of(input int d, input int p);
        return (d != 0) ? b_gnt : ((p != 0) ? m1_gnt : m0_gnt);
    endfunction
    function automatic logic rv_of(input int d, input int p);
        return (d != 0) ? b_rvalid : ((p != 0) ? m1_rvalid : m0_rvalid);
    endfunction

    task automatic drive(input int d, input int p, input logic rq, input logic we,
                         input logic [3:0] a, input logic [31:0] wd);
        if (d != 0) begin
            b_req = rq; b_we = we; b_addr = a; b_wdata = wd;
        end else if (p == 0) begin
            m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = wd;
        end
    endtask

    // One isolated access; request raised in an IDLE cycle t0.
    task automatic access(input int d, input int p, input logic we,
                          input logic [3:0] a, input logic [31:0] wd);
        int   t0;
        int   lat;
        bit   got;
        exp_t e;
        lat = (d != 0) ? 2 : 1;
        @(negedge clk);
        t0 = cyc;
        drive(d, p, 1'b1, we, a, wd);
        if (we) begin
            if (d != 0) ref_b[a] = wd; else ref_a[a] = wd;
        end else begin
            e.port = p;
            e.data = (d != 0) ? ref_b[a] : ref_a[a];
            if (d != 0) sb_b.push_back(e); else sb_a.push_back(e);
        end
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (gnt_of(d, p)) begin
                got = 1'b1;
                check("gnt_latency", cyc - t0, 1);
                check("gnt_mem_en", (d != 0) ? b_mem_en : mem_en, 1);
                check("gnt_mem_we", (d != 0) ? b_mem_we : mem_we, we);
                check("gnt_mem_addr", (d != 0) ? b_mem_addr : mem_addr, a);
                if (we) check("gnt_mem_wdata", (d != 0) ? b_mem_wdata : mem_wdata, wd);
                drive(d, p, 1'b0, we, a, wd);
            end
        end
        check("gnt_seen", got, 1);
        if (!we) begin
            got = 1'b0;
            for (int k = 0; k < 12 && !got; k++) begin
                @(negedge clk);
                if (rv_of(d, p)) begin
                    got = 1'b1;
                    check("rv_latency", cyc - t0, 2 + lat);
                end
            end
            check("rv_seen", got, 1);
        end
        @(negedge clk);
        check("idle_after", (d != 0) ? b_busy : busy, 0);
    endtask

    task automatic drain_a();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb_a.size() == 0 && !busy) break;
        end
        check("a_drain", sb_a.size(), 0);
    endtask

    // Hold requests on DUT A until each port has n grants; log grant order/cycle.
    task automatic run_stream(input int n0, input int n1, input bit m0_late, input bit inc);
        int g0 = 0;
        int g1 = 0;
        m0_req = (n0 > 0) && !m0_late;
        m1_req = (n1 > 0);
        for (int k = 0; k < 200 && (g0 < n0 || g1 < n1); k++) begin
            @(negedge clk);
            if (m0_gnt) begin
                gport.push_back(0); gcyc.push_back(cyc); g0++;
                if (g0 >= n0) m0_req = 1'b0;
                else if (inc) m0_addr = m0_addr + 4'd1;
            end
            if (m1_gnt) begin
                gport.push_back(1); gcyc.push_back(cyc); g1++;
                if (g1 >= n1) m1_req = 1'b0;
                else if (inc) m1_addr = m1_addr + 4'd1;
                if (m0_late && g1 == 1 && n0 > 0) m0_req = 1'b1;
            end
        end
        check("stream_grants", g0 + g1, n0 + n1);
        drain_a();
    endtask

    task automatic push_a(input int p, input int a);
        exp_t e;
        e.port = p;
        e.data = ref_a[a];
        sb_a.push_back(e);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int i = 0; i < 16; i++) begin
            ref_a[i] = pat(i);
            ref_b[i] = pat(i);
        end
        drive(0, 0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive(0, 1, 1'b0, 1'b0, 4'd0, 32'd0);
        drive(1, 0, 1'b0, 1'b0, 4'd0, 32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_en, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_b_busy", b_busy, 0);
        rst = 1'b0;
        preload = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_mem_en", mem_en, 0);
        end

        // Write then read back on port 0; rdata must ignore later writes
        access(0, 0, 1'b1, 4'd3, 32'hDEAD_BEEF);
        access(0, 0, 1'b0, 4'd3, 32'd0);
        check("rdata_after_read", rdata, 32'hDEAD_BEEF);
        access(0, 0, 1'b1, 4'd3, 32'h1111_2222);
        check("rdata_hold_on_write", rdata, 32'hDEAD_BEEF);
        access(0, 1, 1'b0, 4'd3, 32'd0);

        // Both ports reading continuously from reset: strict alternation
        pulse_reset();
        m0_we = 1'b0; m0_addr = 4'd0;
        m1_we = 1'b0; m1_addr = 4'd8;
        for (int i = 0; i < 3; i++) begin
            push_a(0, i);
            push_a(1, 8 + i);
        end
        gport.delete(); gcyc.delete();
        run_stream(3, 3, 1'b0, 1'b1);
        check("rr_count", gport.size(), 6);
        for (int i = 0; i < gport.size(); i++) check("rr_order", gport[i], i % 2);

        // Lone m1 reads back-to-back every 4 cycles
        m1_we = 1'b0; m1_addr = 4'd5;
        for (int i = 0; i < 3; i++) push_a(1, 5);
        gport.delete(); gcyc.delete();
        run_stream(0, 3, 1'b0, 1'b0);
        for (int i = 1; i < gcyc.size(); i++) check("b2b_read_gap", gcyc[i] - gcyc[i-1], 4);

        // Lone m1 writes back-to-back every 2 cycles
        m1_we = 1'b1; m1_addr = 4'd6; m1_wdata = 32'hA5A5_0006;
        ref_a[6] = 32'hA5A5_0006;
        gport.delete(); gcyc.delete();
        run_stream(0, 3, 1'b0, 1'b0);
        for (int i = 1; i < gcyc.size(); i++) check("b2b_write_gap", gcyc[i] - gcyc[i-1], 2);

        // m1 holding req, m0 joins: m0 wins the next arbitration
        m1_we = 1'b0; m1_addr = 4'd6;
        m0_we = 1'b0; m0_addr = 4'd7;
        push_a(1, 6); push_a(0, 7); push_a(1, 6);
        gport.delete(); gcyc.delete();
        run_stream(1, 2, 1'b1, 1'b0);
        check("join_count", gport.size(), 3);
        if (gport.size() == 3) begin
            check("join_first", gport[0], 1);
            check("join_second", gport[1], 0);
            check("join_third", gport[2], 1);
        end

        // Reset during WAIT of an m1 read drops it
        @(negedge clk);
        drive(0, 1, 1'b1, 1'b0, 4'd9, 32'd0);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (m1_gnt) begin
                got = 1'b1;
                drive(0, 1, 1'b0, 1'b0, 4'd9, 32'd0);
            end
        end
        check("t5_gnt_seen", got, 1);
        @(negedge clk);
        check("t5_busy_in_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_idle", busy, 0);
        check("t5_rdata_cleared", rdata, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        access(0, 0, 1'b0, 4'd9, 32'd0);

        // RD_LATENCY=2 build
        access(1, 0, 1'b1, 4'd4, 32'h1234_5678);
        access(1, 0, 1'b0, 4'd4, 32'd0);
        access(1, 0, 1'b0, 4'd11, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_a_empty", sb_a.size(), 0);
        check("sb_b_empty", sb_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
